// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - dispatch record type, issue sizing and serialisation helper
package pipeline_types;

  localparam int DISPATCH_DEPTH = 8;
  localparam int ISSUE_WIDTH    = 2;
  localparam int NUM_READ_PORTS = 2;

  typedef struct packed {
    logic [31:0]                  pc;
    logic                         reg_write_en;
    logic [4:0]                   reg_write_addr;
    logic [NUM_READ_PORTS-1:0]    reg_read_en;
    logic [NUM_READ_PORTS-1:0][4:0] reg_read_addr;
    logic                         is_privilege;
    logic                         csr_read_en;
    logic                         csr_write_en;
    logic                         is_cnt;
    logic [5:0]                   is_exception;
  } id_dispatch_t;

  // Records that must issue alone: privileged ops, CSR access, counters, exceptions.
  function automatic logic is_serialising(input id_dispatch_t d);
    return d.is_privilege | d.csr_read_en | d.csr_write_en | d.is_cnt |
           (d.is_exception != '0);
  endfunction

endpackage

// File: rtl/dispatch_queue_scheduler_hazard_check.sv
// rtl/dispatch_queue_scheduler_hazard_check.sv - pairwise dual-issue hazard detector
module dispatch_hazard_check
  import pipeline_types::*;
(
  input  id_dispatch_t i_e0,
  input  id_dispatch_t i_e1,
  output logic         o_hazard
);

  logic w_raw;

  // Younger record may not pair with the older one on a RAW dependency or serialisation.
  always_comb begin
    w_raw = 1'b0;
    if (i_e0.reg_write_en && (i_e0.reg_write_addr != 5'd0)) begin
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
        if (i_e1.reg_read_en[i] && (i_e1.reg_read_addr[i] == i_e0.reg_write_addr))
          w_raw = 1'b1;
      end
    end
    o_hazard = w_raw | is_serialising(i_e0) | is_serialising(i_e1);
  end

endmodule

// File: rtl/dispatch_queue_scheduler.sv
// rtl/dispatch_queue_scheduler.sv - in-order dual-enqueue / dual-issue dispatch queue
module dispatch_queue_scheduler
  import pipeline_types::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            enq_valid,
  input  id_dispatch_t [1:0]    enq_data,
  output logic                  enq_ready,
  input  logic                  issue_stall,
  output logic [1:0]            issue_valid,
  output id_dispatch_t [1:0]    issue_data,
  output logic [PTR_W:0]        occupancy
);

  localparam logic [PTR_W:0] ENQ_LIMIT = (PTR_W+1)'(DEPTH - 2);

  id_dispatch_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  logic             w_present0;
  logic             w_present1;
  logic             w_hazard;
  logic [1:0]       w_n_enq;
  logic [1:0]       w_n_deq;

  assign w_head1    = r_head + 1'b1;
  assign w_tail1    = r_tail + 1'b1;
  assign w_present0 = (r_count != '0);
  assign w_present1 = (r_count >= (PTR_W+1)'(2));

  assign enq_ready   = (r_count <= ENQ_LIMIT);
  assign occupancy   = r_count;
  assign issue_data[0] = r_mem[r_head];
  assign issue_data[1] = r_mem[w_head1];

  dispatch_hazard_check u_hazard (
    .i_e0     (issue_data[0]),
    .i_e1     (issue_data[1]),
    .o_hazard (w_hazard)
  );

  // Issue selection and enqueue/dequeue amounts; flush overrides everything.
  always_comb begin
    issue_valid[0] = w_present0 & ~flush;
    issue_valid[1] = w_present1 & ~flush & ~w_hazard;
    if (flush || !enq_ready || !enq_valid[0])
      w_n_enq = 2'd0;
    else
      w_n_enq = enq_valid[1] ? 2'd2 : 2'd1;
    if (issue_stall || flush)
      w_n_deq = 2'd0;
    else
      w_n_deq = {1'b0, issue_valid[0]} + {1'b0, issue_valid[1]};
  end

  // Entry storage: slot 0 lands at tail, slot 1 at tail+1; no reset needed.
  always_ff @(posedge clk) begin
    if (w_n_enq != 2'd0) r_mem[r_tail]  <= enq_data[0];
    if (w_n_enq == 2'd2) r_mem[w_tail1] <= enq_data[1];
  end

  // Pointer and count update; count disambiguates head==tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_deq);
      r_tail  <= r_tail + PTR_W'(w_n_enq);
      r_count <= r_count + (PTR_W+1)'(w_n_enq) - (PTR_W+1)'(w_n_deq);
    end
  end

endmodule

// File: tb/tb_dispatch_queue_scheduler.sv
// tb/tb_dispatch_queue_scheduler.sv - randomized and directed bench with queue reference model
module tb_dispatch_queue_scheduler;
  import pipeline_types::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic [1:0]         enq_valid = 2'b00;
  id_dispatch_t [1:0] enq_data;
  logic               enq_ready;
  logic               issue_stall = 1'b0;
  logic [1:0]         issue_valid;
  id_dispatch_t [1:0] issue_data;
  logic [PTR_W:0]     occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  id_dispatch_t q[$];

  always #5 clk = ~clk;

  dispatch_queue_scheduler #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_data    (enq_data),
    .enq_ready   (enq_ready),
    .issue_stall (issue_stall),
    .issue_valid (issue_valid),
    .issue_data  (issue_data),
    .occupancy   (occupancy)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_serial(input id_dispatch_t d);
    return d.is_privilege || d.csr_read_en || d.csr_write_en || d.is_cnt || (d.is_exception != 0);
  endfunction

  function automatic bit ref_conflict(input id_dispatch_t a, input id_dispatch_t b);
    bit raw = 0;
    if (a.reg_write_en && a.reg_write_addr != 0)
      for (int i = 0; i < 2; i++)
        if (b.reg_read_en[i] && b.reg_read_addr[i] == a.reg_write_addr) raw = 1;
    return raw || ref_serial(a) || ref_serial(b);
  endfunction

  function automatic id_dispatch_t mk(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                                      input logic [1:0] re, input logic [4:0] rs1, input logic [4:0] rs2);
    id_dispatch_t d;
    d = '0;
    d.pc = pc; d.reg_write_en = we; d.reg_write_addr = rd;
    d.reg_read_en = re; d.reg_read_addr[0] = rs1; d.reg_read_addr[1] = rs2;
    return d;
  endfunction

  function automatic id_dispatch_t rand_rec(input logic [31:0] pc);
    id_dispatch_t d;
    d = mk(pc, 1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 4))
        0: d.is_privilege = 1'b1;
        1: d.csr_read_en  = 1'b1;
        2: d.csr_write_en = 1'b1;
        3: d.is_cnt       = 1'b1;
        default: d.is_exception = 6'($urandom_range(1, 63));
      endcase
    end
    return d;
  endfunction

  function automatic logic [1:0] model_iv();
    logic [1:0] v = 2'b00;
    if (!flush && q.size() >= 1) v[0] = 1'b1;
    if (!flush && q.size() >= 2 && !ref_conflict(q[0], q[1])) v[1] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic [1:0] ev, input id_dispatch_t d0, input id_dispatch_t d1,
                       input logic st, input logic fl);
    enq_valid = ev; enq_data[0] = d0; enq_data[1] = d1; issue_stall = st; flush = fl;
  endtask

  task automatic settle();
    logic [1:0] v;
    #1;
    v = model_iv();
    expect_eq("issue_valid", issue_valid, v);
    expect_eq("enq_ready", enq_ready, (q.size() <= DEPTH - 2));
    expect_eq("occupancy", occupancy, q.size());
    if (v[0]) expect_eq("issue_data0", issue_data[0], q[0]);
    if (v[1]) expect_eq("issue_data1", issue_data[1], q[1]);
  endtask

  task automatic tick();
    logic [1:0] v;
    bit ready;
    v = model_iv();
    ready = (q.size() <= DEPTH - 2);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (!issue_stall) begin
        if (v[0]) void'(q.pop_front());
        if (v[1]) void'(q.pop_front());
      end
      if (ready && enq_valid[0]) begin
        q.push_back(enq_data[0]);
        if (enq_valid[1]) q.push_back(enq_data[1]);
      end
    end
    @(negedge clk);
  endtask

  id_dispatch_t idle_rec;
  logic [31:0]  exp_pc;
  int           guard;

  initial begin
    idle_rec = '0;
    drive(2'b00, idle_rec, idle_rec, 1'b0, 1'b0);
    #1;
    expect_eq("reset_occupancy", occupancy, 0);
    expect_eq("reset_issue_valid", issue_valid, 2'b00);
    expect_eq("reset_enq_ready", enq_ready, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Independent pair dual-issues
    drive(2'b11, mk(32'h100, 1, 4, 2'b11, 1, 2), mk(32'h104, 1, 5, 2'b11, 3, 6), 0, 0);
    settle(); tick();
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    settle(); expect_eq("pair_iv", issue_valid, 2'b11); tick();
    settle(); expect_eq("pair_drained", occupancy, 0);

    // RAW on r4 splits the pair
    drive(2'b11, mk(32'h200, 1, 4, 2'b00, 0, 0), mk(32'h204, 1, 5, 2'b11, 4, 1), 0, 0);
    settle(); tick();
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    settle(); expect_eq("raw_iv0", issue_valid, 2'b01); tick();
    settle(); expect_eq("raw_iv1", issue_valid, 2'b01);
    expect_eq("raw_pc1", issue_data[0].pc, 32'h204); tick();
    settle(); expect_eq("raw_empty", occupancy, 0);

    // Write to r0 creates no dependency
    drive(2'b11, mk(32'h300, 1, 0, 2'b00, 0, 0), mk(32'h304, 1, 7, 2'b01, 0, 0), 0, 0);
    settle(); tick();
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    settle(); expect_eq("r0_iv", issue_valid, 2'b11); tick();

    // Fill under stall, odd start so occupancy lands on 7; pointers wrap on drain
    drive(2'b01, mk(32'h400, 1, 9, 2'b11, 1, 2), idle_rec, 1, 0);
    settle(); tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, mk(32'h404 + 8*k, 1, 10, 2'b11, 1, 2), mk(32'h408 + 8*k, 1, 11, 2'b11, 1, 2), 1, 0);
      settle(); tick();
    end
    drive(2'b11, mk(32'hBAD0, 1, 12, 2'b11, 1, 2), mk(32'hBAD4, 1, 13, 2'b11, 1, 2), 1, 0);
    settle();
    expect_eq("full_occ", occupancy, 7);
    expect_eq("full_ready", enq_ready, 1'b0);
    tick();
    settle(); expect_eq("held_occ", occupancy, 7);
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    exp_pc = 32'h400;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      settle();
      if (issue_valid[0]) begin expect_eq("drain_pc0", issue_data[0].pc, exp_pc); exp_pc += 4; end
      if (issue_valid[1]) begin expect_eq("drain_pc1", issue_data[1].pc, exp_pc); exp_pc += 4; end
      tick();
      guard++;
    end
    expect_eq("drain_count", exp_pc, 32'h41C);
    expect_eq("drain_occ", occupancy, 0);

    // Serialising head record issues alone
    begin
      id_dispatch_t s;
      s = mk(32'h500, 1, 3, 2'b00, 0, 0);
      s.csr_write_en = 1'b1;
      drive(2'b11, s, mk(32'h504, 1, 8, 2'b11, 9, 10), 0, 0);
    end
    settle(); tick();
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    settle(); expect_eq("ser_iv0", issue_valid, 2'b01); tick();
    settle(); expect_eq("ser_iv1", issue_valid, 2'b01); tick();

    // Flush at occupancy 6 with a simultaneous dual enqueue
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, mk(32'h600 + 8*k, 1, 1, 2'b00, 0, 0), mk(32'h604 + 8*k, 1, 2, 2'b00, 0, 0), 1, 0);
      settle(); tick();
    end
    drive(2'b11, mk(32'h700, 1, 1, 2'b00, 0, 0), mk(32'h704, 1, 2, 2'b00, 0, 0), 0, 1);
    settle();
    expect_eq("flush_pre_occ", occupancy, 6);
    expect_eq("flush_iv", issue_valid, 2'b00);
    tick();
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    settle();
    expect_eq("flush_occ", occupancy, 0);
    expect_eq("flush_ready", enq_ready, 1'b1);

    // Asynchronous reset mid-stream
    drive(2'b11, mk(32'h800, 1, 1, 2'b00, 0, 0), mk(32'h804, 1, 2, 2'b00, 0, 0), 1, 0);
    settle(); tick();
    settle(); tick();
    expect_eq("prereset_occ", occupancy, 4);
    #2 rst = 1'b0;
    #1;
    expect_eq("async_rst_occ", occupancy, 0);
    expect_eq("async_rst_iv", issue_valid, 2'b00);
    q.delete();
    drive(2'b00, idle_rec, idle_rec, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      drive(2'($urandom), rand_rec(32'h10000 + 8*c), rand_rec(32'h10004 + 8*c),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue_scheduler.md
Name: dispatch_queue_scheduler

Overview:
- Sits between the parallel instruction decoders and the execute/issue stage.
- Buffers up to two decoded `id_dispatch_t` records per cycle in an in-order circular queue.
- Each cycle it issues up to two records in program order. The second slot is issued only when it has no RAW or serialising hazard against the first.
- Provides back-pressure to decode and discards all contents on a pipeline flush.

Parameters:
- DEPTH, 8, number of queue entries. Must be a power of two, ≥4.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all queued and presented entries.
- enq_valid  in  2  per-slot decode valid. Slot 1 is meaningful only with slot 0.
- enq_data  in  2 x id_dispatch_t  decoded records. Slot 0 is older.
- enq_ready  out  1  queue can accept two entries this cycle.
- issue_stall  in  1  issue stage cannot accept this cycle.
- issue_valid  out  2  per-slot issue valid.
- issue_data  out  2 x id_dispatch_t  records at head and head+1.
- occupancy  out  PTR_W+1  current entry count, 0..DEPTH.

Behaviour:
- Reset (rst=0, async):
  - head=0, tail=0, count=0.
  - Outputs: issue_valid=2'b00, enq_ready=1, occupancy=0.
  - Entry storage is not reset.
- Enqueue:
  - enq_ready = (count ≤ DEPTH-2), combinational from registered count.
  - n_enq = 0 when enq_ready=0 or flush=1. Otherwise n_enq = enq_valid[0] + (enq_valid[0] & enq_valid[1]).
  - enq_valid=2'b10 is treated as no enqueue (n_enq=0).
  - Slot 0 is written at tail, slot 1 at tail+1 (mod DEPTH). tail advances by n_enq.
  - A written entry is first visible on issue_data the next cycle. There is no same-cycle bypass.
- Issue, combinational from registered state:
  - Candidate 0 = entry[head], present when count ≥1. Candidate 1 = entry[head+1], present when count ≥2.
  - issue_valid[0] = present0 & ~flush.
  - issue_valid[1] = present1 & ~flush & ~hazard.
  - hazard is set when either of these holds:
    - RAW: e0.reg_write_en, e0.reg_write_addr≠0, and for some i, e1.reg_read_en[i] with e1.reg_read_addr[i]==e0.reg_write_addr.
    - Serialising: e0 or e1 has any of is_privilege, csr_read_en, csr_write_en, is_cnt set, or is_exception≠0.
  - issue_valid[1] is never 1 while issue_valid[0] is 0.
- Dequeue:
  - n_deq = 0 if issue_stall or flush. Otherwise n_deq = popcount(issue_valid).
  - head advances by n_deq (mod DEPTH).
- Count:
  - count_next = count + n_enq − n_deq. Enqueue and dequeue in the same cycle are both honoured.
  - Full: count=DEPTH-1 or DEPTH gives enq_ready=0. Decode must hold its inputs.
  - Empty: count=0 gives issue_valid=00. count=1 gives single issue only.
- Wrap-around: pointers roll over modulo DEPTH. Since count tracks fullness, head==tail is unambiguous.
- Flush: highest priority. Next cycle head=tail=count=0. Same-cycle enqueue is dropped and same-cycle issue_valid is forced to 00.
- issue_stall=1: outputs remain stable, and the issue pair may be re-evaluated only after new state arrives (head unchanged).
- Reset mid-operation: state is cleared immediately and asynchronously. Operation resumes on the first clk edge after rst deasserts.

Decomposition:
- pipeline_types package:
  - DISPATCH_DEPTH default.
  - ISSUE_WIDTH=2.
  - Function `is_serialising(id_dispatch_t)`.
- Sub-module dispatch_hazard_check (combinational):
  - Inputs: two id_dispatch_t records.
  - Output: 1-bit hazard.
  - Reused by later dual-issue logic.
- Storage: flat register array inside the top module. No RAM macro.

Test Plan:
- Reset then enqueue the pair add.w r4←r1,r2 / add.w r5←r3,r6. Next cycle: issue_valid=11, and occupancy returns to 0 after the issue.
- RAW: lu12i.w r4 (write r4) followed by add.w r5←r4,r1. Required response:
  - First cycle: issue_valid=01.
  - Next cycle: issue_valid=01 with the add, then empty.
- Write to r0: e0 writes r0 and e1 reads r0. issue_valid=11, i.e. no hazard.
- Fill with issue_stall=1 and dual enqueues each cycle:
  - enq_ready drops when occupancy reaches 7.
  - Held enqueues are not written.
  - Release stall: entries drain in order through the pointer wrap. Check pc sequence intact.
- Serialising: e0.csr_write_en=1 behind a normal e1. issue_valid=01, then 01.
- Flush with occupancy=6 and a simultaneous enq_valid=11:
  - Same cycle: issue_valid=00.
  - Next cycle: occupancy=0 and enq_ready=1.
  - Then assert rst low mid-stream: occupancy=0 immediately, before the next clk edge.
